spi_master: RTL and testbench

- Byte-oriented SPI bus master (mode 0: CPOL=0, CPHA=0; MSB first) with programmable SCK prescaler and one-hot chip-select for up to NUM_TARGETS targets.
- Sits between a host-side register/bridge and the external SPI flash/peripherals.
- Host enqueues one tx byte at a time via a ready/enable handshake.
- Each completed byte yields the simultaneously received byte with a one-cycle strobe.

---
 rtl/spi_master.sv | 141 ++++++++++++++
 tb/tb_spi_master.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI mode-0 master with programmable SCK prescaler and one-hot chip selects.
// Define SPI_MASTER_LSB_FIRST_EN to shift LSB first; the default build shifts MSB first.
module spi_master #(
  parameter int NUM_TARGETS = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             prescaler,
  output logic                   spi_clk,
  output logic [NUM_TARGETS-1:0] spi_csn,
  output logic                   spi_mosi,
  output logic                   spi_mosi_drive,
  input  logic                   spi_miso,
  input  logic [NUM_TARGETS-1:0] target_id,
  input  logic                   target_en,
  input  logic [7:0]             tx_byte,
  input  logic                   tx_en,
  output logic                   tx_ready,
  output logic [7:0]             rx_byte,
  output logic                   rx_en
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [8:0]             r_half;
  logic [8:0]             r_preCnt;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_sample;
  logic                   r_sck;
  logic                   r_mosi;
  logic                   r_mosiDrive;
  logic                   r_txReady;
  logic                   r_rxEn;
  logic [7:0]             r_rxByte;
  logic [NUM_TARGETS-1:0] r_csn;

  logic       w_accept;
  logic       w_halfDone;
  logic       w_lastFall;
  logic [7:0] w_shifted;
  logic       w_nextBit;

  // The sampled MISO bit is merged in on the falling edge so the outgoing bits are never overwritten.
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_shifted = {r_sample, r_shift[7:1]};
  assign w_nextBit = r_shift[1];
`else
  assign w_shifted = {r_shift[6:0], r_sample};
  assign w_nextBit = r_shift[6];
`endif

  always_comb begin
    w_accept    = 1'b0;
    w_halfDone  = 1'b0;
    w_lastFall  = 1'b0;
    w_nextState = r_state;
    if (r_state == IDLE) begin
      w_accept = tx_en & r_txReady & target_en;
      if (w_accept) w_nextState = SHIFT;
    end else begin
      w_halfDone = (r_preCnt == (r_half - 9'd1));
      w_lastFall = w_halfDone & r_sck & (r_bitCnt == 3'd7);
      if (!target_en || w_lastFall) w_nextState = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_half      <= '0;
      r_preCnt    <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_sample    <= 1'b0;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_mosiDrive <= 1'b0;
      r_txReady   <= 1'b0;
      r_rxEn      <= 1'b0;
      r_rxByte    <= '0;
      r_csn       <= '1;
    end else begin
      r_csn       <= ~({NUM_TARGETS{target_en}} & target_id);
      r_mosiDrive <= target_en & (|target_id);
      r_rxEn      <= 1'b0;
      if (r_state == IDLE) begin
        r_sck     <= 1'b0;
        r_txReady <= target_en;
        if (w_accept) begin
          r_half    <= {1'b0, prescaler} + 9'd1;
          r_preCnt  <= '0;
          r_bitCnt  <= '0;
          r_shift   <= tx_byte;
          r_txReady <= 1'b0;
`ifdef SPI_MASTER_LSB_FIRST_EN
          r_mosi    <= tx_byte[0];
`else
          r_mosi    <= tx_byte[7];
`endif
        end
      end else if (!target_en) begin
        r_sck     <= 1'b0;
        r_txReady <= 1'b0;
      end else if (w_halfDone) begin
        r_preCnt <= '0;
        r_sck    <= ~r_sck;
        if (!r_sck) begin
          r_sample <= spi_miso;
        end else begin
          r_shift  <= w_shifted;
          r_bitCnt <= r_bitCnt + 3'd1;
          if (w_lastFall) begin
            r_rxByte  <= w_shifted;
            r_rxEn    <= 1'b1;
            r_txReady <= target_en;
          end else begin
            r_mosi <= w_nextBit;
          end
        end
      end else begin
        r_preCnt <= r_preCnt + 9'd1;
      end
    end
  end

  assign spi_clk        = r_sck;
  assign spi_csn        = r_csn;
  assign spi_mosi       = r_mosi;
  assign spi_mosi_drive = r_mosiDrive;
  assign tx_ready       = r_txReady;
  assign rx_byte        = r_rxByte;
  assign rx_en          = r_rxEn;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: randomized bytes against a bit-order/timing reference model.
// Follows SPI_MASTER_LSB_FIRST_EN in the same way as the design.
module tb_spi_master;

  localparam int NT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    prescaler = 8'd0;
  logic          spi_clk;
  logic [NT-1:0] spi_csn;
  logic          spi_mosi;
  logic          spi_mosi_drive;
  logic          spi_miso;
  logic [NT-1:0] target_id = '0;
  logic          target_en = 1'b0;
  logic [7:0]    tx_byte = 8'd0;
  logic          tx_en = 1'b0;
  logic          tx_ready;
  logic [7:0]    rx_byte;
  logic          rx_en;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic       loopback = 1'b1;
  logic [7:0] slaveWord = 8'd0;
  logic [2:0] slaveIdx = 3'd0;
  logic [7:0] expLastRx = 8'd0;

  spi_master #(.NUM_TARGETS(NT)) dut (
    .clk(clk), .reset(reset), .prescaler(prescaler),
    .spi_clk(spi_clk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_mosi_drive(spi_mosi_drive), .spi_miso(spi_miso),
    .target_id(target_id), .target_en(target_en),
    .tx_byte(tx_byte), .tx_en(tx_en), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_en(rx_en)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: presents slaveWord MSB-first in time order, advancing on each SCK fall.
  always @(negedge spi_clk) if (slaveIdx < 3'd7) slaveIdx = slaveIdx + 3'd1;
  assign spi_miso = loopback ? spi_mosi : slaveWord[3'd7 - slaveIdx];

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  // Time-ordered wire sequence of a tx byte, and rx byte built from a time-ordered sequence.
  function automatic logic [7:0] wireOrder(input logic [7:0] v);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return rev8(v);
`else
    return v;
`endif
  endfunction

  function automatic logic [7:0] expRx(input logic [7:0] timeWord);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return rev8(timeWord);
`else
    return timeWord;
`endif
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one byte and observes the bus until rx_en, a cycle budget, or stopRises SCK rises.
  task automatic runByte(input logic [7:0] txb, input logic [7:0] sw, input int h,
                         input int stopRises, output logic [7:0] mosiWord,
                         output int doneDelta, output int nRises, output int riseErr,
                         output logic csnChanged, output logic [NT-1:0] csnFirst,
                         output logic [7:0] rxv, output logic readyAtDone);
    int   tStart;
    logic prevSck;
    slaveWord = sw;
    slaveIdx  = 3'd0;
    prescaler = 8'(h - 1);
    tx_byte   = txb;
    tx_en     = 1'b1;
    @(posedge clk);
    #1;
    tx_en       = 1'b0;
    tStart      = cyc;
    prescaler   = 8'($urandom);
    mosiWord    = 8'd0;
    doneDelta   = -1;
    nRises      = 0;
    riseErr     = 0;
    csnChanged  = 1'b0;
    csnFirst    = spi_csn;
    rxv         = 8'd0;
    readyAtDone = 1'b0;
    prevSck     = spi_clk;
    for (int i = 0; i < 16 * h + 8; i++) begin
      @(posedge clk);
      #1;
      if (spi_csn !== csnFirst) csnChanged = 1'b1;
      if (spi_clk && !prevSck) begin
        if (cyc - tStart != (2 * nRises + 1) * h) riseErr++;
        mosiWord = {mosiWord[6:0], spi_mosi};
        nRises++;
      end
      prevSck = spi_clk;
      if (rx_en) begin
        doneDelta   = cyc - tStart;
        rxv         = rx_byte;
        readyAtDone = tx_ready;
        break;
      end
      if (stopRises > 0 && nRises == stopRises) break;
    end
  endtask

  task automatic test_reset;
    logic sawRx;
    reset = 1'b1;
    tick(3);
    vectors++;
    if ({spi_clk, spi_mosi, spi_mosi_drive, tx_ready, rx_en} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {spi_clk, spi_mosi, spi_mosi_drive, tx_ready, rx_en});
    end
    vectors++;
    if (spi_csn !== '1 || rx_byte !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_data: csn %b rx %h expected csn 11 rx 00", spi_csn, rx_byte);
    end
    reset = 1'b0;
    sawRx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rx_en || spi_clk || tx_ready) sawRx = 1'b1;
    end
    vectors++;
    if (sawRx !== 1'b0 || spi_csn !== '1) begin
      miscompares++;
      $display("[TB] FAIL idle_quiet: activity %b csn %b expected 0 and 11", sawRx, spi_csn);
    end
  endtask

  task automatic test_select;
    prescaler = 8'd1;
    target_id = 2'b01;
    target_en = 1'b1;
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL select_latency: tx_ready %b expected 0", tx_ready);
    end
    tick(1);
    vectors++;
    if ({spi_csn, tx_ready, spi_mosi_drive} !== {2'b10, 1'b1, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL select: csn %b ready %b drive %b expected 10 1 1", spi_csn, tx_ready, spi_mosi_drive);
    end
  endtask

  task automatic test_loopback;
    logic [7:0] mw, rxv;
    logic [NT-1:0] cf;
    logic cc, rdy;
    int dd, nr, re;
    loopback = 1'b1;
    runByte(8'hA5, 8'h00, 2, 0, mw, dd, nr, re, cc, cf, rxv, rdy);
    expLastRx = expRx(wireOrder(8'hA5));
    vectors++;
    if (mw !== wireOrder(8'hA5) || nr != 8 || re != 0) begin
      miscompares++;
      $display("[TB] FAIL loop_sck: mosi %h rises %0d late %0d expected %h 8 0", mw, nr, re, wireOrder(8'hA5));
    end
    vectors++;
    if (dd != 32 || rxv !== expLastRx || rdy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL loop_done: at %0d rx %h ready %b expected 32 %h 1", dd, rxv, rdy, expLastRx);
    end
    tick(1);
    vectors++;
    if (rx_en !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL loop_strobe: rx_en %b expected 0", rx_en);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] mw, rxv, b[2];
    logic [NT-1:0] cf;
    logic cc, rdy;
    int dd, nr, re;
    b[0] = 8'h3C;
    b[1] = 8'hFF;
    loopback = 1'b1;
    for (int k = 0; k < 2; k++) begin
      runByte(b[k], 8'h00, 2, 0, mw, dd, nr, re, cc, cf, rxv, rdy);
      expLastRx = expRx(wireOrder(b[k]));
      vectors++;
      if (rxv !== expLastRx || dd != 32 || re != 0 || rdy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_byte%0d: rx %h at %0d late %0d ready %b expected %h 32 0 1", k, rxv, dd, re, rdy, expLastRx);
      end
      vectors++;
      if (cc !== 1'b0 || cf !== 2'b10) begin
        miscompares++;
        $display("[TB] FAIL b2b_cs%0d: changed %b first %b expected 0 10", k, cc, cf);
      end
    end
  endtask

  task automatic test_prescaler;
    logic [7:0] mw, rxv, txb, sw;
    logic [NT-1:0] cf;
    logic cc, rdy;
    int dd, nr, re, h;
    loopback = 1'b0;
    for (int k = 0; k < 2; k++) begin
      h   = (k == 0) ? 1 : 8;
      txb = 8'($urandom);
      sw  = 8'($urandom);
      runByte(txb, sw, h, 0, mw, dd, nr, re, cc, cf, rxv, rdy);
      expLastRx = expRx(sw);
      vectors++;
      if (dd != 16 * h || re != 0 || nr != 8) begin
        miscompares++;
        $display("[TB] FAIL presc_h%0d: done %0d late %0d rises %0d expected %0d 0 8", h, dd, re, nr, 16 * h);
      end
      vectors++;
      if (rxv !== expLastRx || mw !== wireOrder(txb)) begin
        miscompares++;
        $display("[TB] FAIL presc_data_h%0d: rx %h mosi %h expected %h %h", h, rxv, mw, expLastRx, wireOrder(txb));
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] mw, rxv, txb, sw;
    logic [NT-1:0] cf;
    logic cc, rdy;
    int dd, nr, re, h;
    loopback = 1'b0;
    for (int k = 0; k < 8; k++) begin
      h   = int'($urandom_range(1, 4));
      txb = 8'($urandom);
      sw  = 8'($urandom);
      runByte(txb, sw, h, 0, mw, dd, nr, re, cc, cf, rxv, rdy);
      expLastRx = expRx(sw);
      vectors++;
      if (rxv !== expLastRx || mw !== wireOrder(txb) || dd != 16 * h || re != 0) begin
        miscompares++;
        $display("[TB] FAIL random%0d: rx %h mosi %h done %0d late %0d expected %h %h %0d 0",
                 k, rxv, mw, dd, re, expLastRx, wireOrder(txb), 16 * h);
      end
      if ($urandom_range(0, 1) == 1) tick(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic test_ignore;
    logic active;
    target_en = 1'b0;
    tick(2);
    tx_byte = 8'h81;
    tx_en   = 1'b1;
    tick(1);
    tx_en  = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (spi_clk || rx_en) active = 1'b1;
    end
    vectors++;
    if (active !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_not_ready: activity %b expected 0", active);
    end
    target_en = 1'b1;
    tick(2);
    tx_en     = 1'b1;
    target_en = 1'b0;
    tick(1);
    tx_en  = 1'b0;
    active = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (spi_clk || rx_en || tx_ready) active = 1'b1;
    end
    vectors++;
    if (active !== 1'b0 || spi_csn !== '1) begin
      miscompares++;
      $display("[TB] FAIL ignore_en_drop: activity %b csn %b expected 0 11", active, spi_csn);
    end
  endtask

  task automatic test_no_target;
    logic [7:0] mw, rxv, sw;
    logic [NT-1:0] cf;
    logic cc, rdy;
    int dd, nr, re;
    target_id = '0;
    target_en = 1'b1;
    loopback  = 1'b0;
    tick(2);
    sw = 8'($urandom);
    runByte(8'h5A, sw, 2, 0, mw, dd, nr, re, cc, cf, rxv, rdy);
    expLastRx = expRx(sw);
    vectors++;
    if (rxv !== expLastRx || dd != 32 || cc !== 1'b0 || cf !== 2'b11 || spi_mosi_drive !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL no_target: rx %h done %0d csn %b chg %b drive %b expected %h 32 11 0 0",
               rxv, dd, cf, cc, spi_mosi_drive, expLastRx);
    end
    target_id = 2'b01;
  endtask

  task automatic test_abort;
    logic [7:0] mw, rxv;
    logic [NT-1:0] cf;
    logic cc, rdy, sawRx;
    int dd, nr, re;
    for (int mode = 0; mode < 2; mode++) begin
      target_id = 2'b01;
      target_en = 1'b1;
      tick(2);
      runByte(8'($urandom), 8'($urandom), 2, 3, mw, dd, nr, re, cc, cf, rxv, rdy);
      if (mode == 0) target_en = 1'b0;
      else reset = 1'b1;
      tick(1);
      if (mode == 1) expLastRx = 8'h00;
      vectors++;
      if (nr != 3 || spi_clk !== 1'b0 || spi_csn !== '1 || tx_ready !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL abort%0d_bus: rises %0d sck %b csn %b ready %b expected 3 0 11 0", mode, nr, spi_clk, spi_csn, tx_ready);
      end
      reset = 1'b0;
      sawRx = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick(1);
        if (rx_en || spi_clk) sawRx = 1'b1;
      end
      vectors++;
      if (sawRx !== 1'b0 || rx_byte !== expLastRx) begin
        miscompares++;
        $display("[TB] FAIL abort%0d_rx: activity %b rx %h expected 0 %h", mode, sawRx, rx_byte, expLastRx);
      end
      target_en = 1'b0;
      tick(2);
    end
  endtask

  initial begin
    tick(1);
    test_reset;
    test_select;
    test_loopback;
    test_back_to_back;
    test_prescaler;
    test_random;
    test_ignore;
    test_no_target;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
